// File: rtl/toggle_pkg.sv
// toggle_pkg: shared defaults and widths for the toggle decoder
package toggle_pkg;
   localparam int SYNC_STAGES_DEF = 2;
   localparam int PEND_MAX_DEF    = 7;
   localparam int CNT_W_DEF       = 16;
   localparam int PEND_W          = 8;
   typedef logic [PEND_W-1:0] pend_t;
endpackage

// File: rtl/toggle_decoder_if.sv
// toggle_decoder_if: event delivery handshake and status from the decoder
interface toggle_decoder_if import toggle_pkg::*; #(
   parameter int CNT_W = CNT_W_DEF
);
   logic             out_valid;
   logic             out_ready;
   pend_t            pend_cnt;
   logic             overflow;
   logic [CNT_W-1:0] evt_count;
   modport master (output out_valid, pend_cnt, overflow, evt_count, input out_ready);
   modport slave  (input out_valid, pend_cnt, overflow, evt_count, output out_ready);
endinterface

// File: rtl/bit_sync.sv
// bit_sync: multi-flop synchronizer for a single asynchronous bit
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);
   logic [STAGES-1:0] sync_q, sync_d;
   // shift the input one stage further down the chain each cycle
   always_comb sync_d = {sync_q[STAGES-2:0], d};
   // chain flops cleared asynchronously so a reset source reads as level 0
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync_q <= '0;
      else sync_q <= sync_d;
   assign q = sync_q[STAGES-1];
endmodule

// File: rtl/toggle_decoder.sv
// toggle_decoder: turns toggle-encoded events into a counted, handshaked event stream
module toggle_decoder import toggle_pkg::*; #(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int PEND_MAX    = PEND_MAX_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input logic              clk,
   input logic              rst_n,
   input logic              tog_in,
   input logic              clr,
   toggle_decoder_if.master bus
);
   logic             sync_out, prev_q, prev_d, evt, pop, full;
   pend_t            pend_q, pend_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   bit_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(tog_in), .q(sync_out));
   assign evt           = sync_out ^ prev_q;
   assign pop           = bus.out_valid & bus.out_ready;
   assign full          = pend_q == pend_t'(PEND_MAX);
   assign bus.out_valid = pend_q != '0;
   assign bus.pend_cnt  = pend_q;
   assign bus.overflow  = ovf_q;
   assign bus.evt_count = cnt_q;
   // prev tracks the chain unconditionally so clr never fabricates an edge; clr beats event/pop
   always_comb begin
      prev_d = sync_out;
      cnt_d  = clr ? '0 : cnt_q + CNT_W'(evt);
      ovf_d  = !clr & (ovf_q | (evt & !pop & full));
      pend_d = clr ? '0 :
               (evt & !pop & !full) ? pend_q + pend_t'(1) :
               (pop & !evt) ? pend_q - pend_t'(1) : pend_q;
   end
   // state registers, cleared asynchronously so nothing pending survives reset
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         prev_q <= 1'b0;
         pend_q <= '0;
         ovf_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         prev_q <= prev_d;
         pend_q <= pend_d;
         ovf_q  <= ovf_d;
         cnt_q  <= cnt_d;
      end
endmodule

// File: tb/tb_toggle_decoder.sv
// tb_toggle_decoder: directed and random checks of toggle_decoder against a behavioural model
module tb_toggle_decoder;
   localparam int S    = 2;
   localparam int PMAX = 7;
   localparam int CW   = 4;
   logic clk = 0, rst_n = 1, tog_in = 0, clr = 0;
   int checks = 0, failures = 0;
   int hist[S+2];
   int m_pend = 0, m_cnt = 0, m_drop = 0, hs = 0, toggles = 0, nvalid;
   bit m_ovf = 0, last_valid = 0;
   toggle_decoder_if #(.CNT_W(CW)) bus ();
   toggle_decoder #(.SYNC_STAGES(S), .PEND_MAX(PMAX), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .tog_in(tog_in), .clr(clr), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask
   task automatic model_reset();
      foreach (hist[i]) hist[i] = 0;
      m_pend = 0; m_cnt = 0; m_ovf = 0; last_valid = 0;
   endtask
   // one clock edge: model advances from spec rules, then all outputs are compared
   task automatic step();
      bit evt, pop;
      @(posedge clk);
      for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = int'(tog_in);
      evt = hist[S] != hist[S+1];
      pop = m_pend > 0 && bus.out_ready;
      if (last_valid && bus.out_ready && !clr) hs++;
      if (clr) begin
         m_pend = 0; m_ovf = 0; m_cnt = 0;
      end else begin
         m_cnt = (m_cnt + int'(evt)) % (1 << CW);
         if (evt && !pop) begin
            if (m_pend == PMAX) begin m_ovf = 1; m_drop++; end
            else m_pend++;
         end else if (pop && !evt) m_pend--;
      end
      #1;
      chk("out_valid", bus.out_valid, m_pend != 0);
      chk("pend_cnt", bus.pend_cnt, m_pend);
      chk("overflow", bus.overflow, m_ovf);
      chk("evt_count", bus.evt_count, m_cnt);
      last_valid = bus.out_valid;
   endtask
   task automatic toggle(int gap);
      tog_in = ~tog_in;
      toggles++;
      repeat (gap) step();
   endtask
   task automatic clear();
      clr = 1; step(); clr = 0;
   endtask
   initial begin
      bus.out_ready = 0;
      model_reset();
      #2 rst_n = 0;
      #2;
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_pend", bus.pend_cnt, 0);
      chk("rst_evt", bus.evt_count, 0);
      @(posedge clk); #1 rst_n = 1;
      // single toggle with consumer ready: one valid cycle
      bus.out_ready = 1;
      repeat (10) step();
      tog_in = 1;
      nvalid = 0;
      repeat (6) begin step(); nvalid += int'(bus.out_valid); end
      chk("single_valid_cycles", nvalid, 1);
      chk("single_evt", bus.evt_count, 1);
      chk("single_pend", bus.pend_cnt, 0);
      // saturation and overflow, then drain
      clear();
      bus.out_ready = 0;
      repeat (9) toggle(3);
      repeat (3) step();
      chk("sat_pend", bus.pend_cnt, 7);
      chk("sat_ovf", bus.overflow, 1);
      chk("sat_evt", bus.evt_count, 9);
      hs = 0;
      bus.out_ready = 1;
      repeat (12) step();
      chk("drain_handshakes", hs, 7);
      // simultaneous event and pop at pend 3 and at full
      clear();
      bus.out_ready = 0;
      repeat (3) toggle(3);
      toggle(2);
      bus.out_ready = 1; step(); bus.out_ready = 0;
      chk("coincide3_pend", bus.pend_cnt, 3);
      repeat (4) toggle(3);
      chk("fill_pend", bus.pend_cnt, 7);
      toggle(2);
      bus.out_ready = 1; step(); bus.out_ready = 0;
      chk("coincide7_pend", bus.pend_cnt, 7);
      chk("coincide7_ovf", bus.overflow, 0);
      // counter wrap and clr colliding with an event
      clear();
      bus.out_ready = 1;
      repeat (17) toggle(3);
      repeat (3) step();
      chk("wrap_evt", bus.evt_count, 1);
      bus.out_ready = 0;
      toggle(2);
      clear();
      chk("clr_evt", bus.evt_count, 0);
      chk("clr_pend", bus.pend_cnt, 0);
      nvalid = 0;
      repeat (5) begin step(); nvalid += int'(bus.out_valid); end
      chk("clr_no_spurious", nvalid, 0);
      // reset mid-operation, tog_in high at release
      repeat (5) toggle(3);
      repeat (3) step();
      chk("pre_rst_pend", bus.pend_cnt, 5);
      tog_in = 1;
      rst_n = 0;
      #1;
      chk("midrst_valid", bus.out_valid, 0);
      chk("midrst_pend", bus.pend_cnt, 0);
      chk("midrst_ovf", bus.overflow, 0);
      chk("midrst_evt", bus.evt_count, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      repeat (2) step();
      chk("rel_valid_early", bus.out_valid, 0);
      step();
      chk("rel_valid", bus.out_valid, 1);
      chk("rel_evt", bus.evt_count, 1);
      // random traffic with conservation scoreboard
      bus.out_ready = 1;
      repeat (4) step();
      clear();
      toggles = 0; hs = 0; m_drop = 0;
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(3) == 0) begin tog_in = ~tog_in; toggles++; end
         bus.out_ready = $urandom_range(1) == 1;
         step();
      end
      bus.out_ready = 0;
      repeat (S + 2) step();
      chk("conservation", hs + m_drop + int'(bus.pend_cnt), toggles);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
